// File: rtl/button_pkg.sv
// Shared encodings and helpers for the button_event block and the menu
// controller that decodes its state values.
package button_pkg;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PRESSED = 2'd1;
  localparam logic [1:0] HELD    = 2'd2;

  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_event_if.sv
// Debounced button level in, classified key-event pulses out.
interface button_event_if;

  logic btn_level;
  logic repeat_en;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn_level, repeat_en,
    input  press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_level, repeat_en,
    output press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, held
  );

endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into registered one-cycle press, release,
// short-click, long-press and auto-repeat pulses plus a held level.
module button_event
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = 1000,
  parameter int unsigned REPEAT_CYCLES = 250
) (
  input  logic           clk,
  input  logic           rst_n,
  button_event_if.slave  ev
);

  localparam int unsigned CW = $clog2(max_cycles(LONG_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST  = CW'(REPEAT_CYCLES - 1);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          short_q, short_d;
  logic          long_q, long_d;
  logic          repeat_q, repeat_d;
  logic          held_q, held_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    short_d   = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (ev.btn_level) begin
          state_d = PRESSED;
          press_d = 1'b1;
          cnt_d   = '0;
        end
      end
      PRESSED: begin
        // cnt restarts at 0 on the cycle after press, so long_pulse lands
        // LONG_CYCLES cycles after press_pulse.
        if (!ev.btn_level) begin
          state_d   = IDLE;
          release_d = 1'b1;
          short_d   = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == LONG_LAST) begin
          state_d = HELD;
          long_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!ev.btn_level) begin
          state_d   = IDLE;
          release_d = 1'b1;
          cnt_d     = '0;
        end else if (cnt_q == REP_LAST) begin
          cnt_d    = '0;
          repeat_d = ev.repeat_en;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HELD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      short_q   <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      short_q   <= short_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      held_q    <= held_d;
    end
  end

  assign ev.press_pulse   = press_q;
  assign ev.release_pulse = release_q;
  assign ev.short_pulse   = short_q;
  assign ev.long_pulse    = long_q;
  assign ev.repeat_pulse  = repeat_q;
  assign ev.held          = held_q;

endmodule
